dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 193 +++++++++++++++++++
 tb/tb_dmem_lsu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit: one outstanding data-memory access, with byte-lane masks, store-data alignment and load extension.
// Latency: accept at edge N, mask pulse in cycle N+1, rsp_valid one cycle after dmem_resp; faults respond in N+1.
// Backpressure: req_ready only in IDLE, so a single request is in flight; dmem side waits indefinitely for dmem_resp.
module dmem_lsu #(
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_store,
  input  logic [2:0]              req_funct3,
  input  logic [31:0]             req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [4:0]              req_rd_s,
  output logic [31:0]             dmem_addr,
  output logic [DATA_W/8-1:0]     dmem_rmask,
  output logic [DATA_W/8-1:0]     dmem_wmask,
  output logic [DATA_W-1:0]       dmem_wdata,
  input  logic [DATA_W-1:0]       dmem_rdata,
  input  logic                    dmem_resp,
  output logic                    rsp_valid,
  output logic                    rsp_we,
  output logic [4:0]              rsp_rd_s,
  output logic [DATA_W-1:0]       rsp_rd_v,
  output logic                    rsp_fault,
  output logic                    busy,
  output logic [15:0]             wait_cnt
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [4:0]        rd_q, rd_d;
  logic              fault_q, fault_d;
  logic              first_q, first_d;
  logic [15:0]       wcnt_q, wcnt_d;

  logic              illegal, misaligned;
  logic [OFF_W-1:0]  off;
  logic [7:0]        ones;
  logic [BYTES-1:0]  lane_mask;
  logic [DATA_W-1:0] shifted, ld_val;
  logic              sign_bit;
  int                nbits;

  assign off = addr_q[OFF_W-1:0];

  // Classify the offered request: unsupported funct3 encodings and size misalignment.
  always_comb begin
    illegal = (req_funct3 == 3'b111) || (req_store && req_funct3[2]) ||
              ((DATA_W == 32) && ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110)));
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Next-state logic: capture on accept, count WAIT cycles, latch read data on completion.
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    fault_d  = fault_q;
    first_d  = 1'b0;
    wcnt_d   = wcnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rd_d     = req_rd_s;
          fault_d  = illegal || misaligned;
          if (illegal || misaligned) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            first_d = 1'b1;
            wcnt_d  = 16'd0;
          end
        end
      end
      WAIT: begin
        wcnt_d = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
        if (dmem_resp) begin
          rdata_d = dmem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane mask and load-result extraction from the captured request and read data.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   ones = 8'h01;
      2'b01:   ones = 8'h03;
      2'b10:   ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    lane_mask = ones[BYTES-1:0] << off;
    shifted   = rdata_q >> {off, 3'b000};
    nbits     = 8 << funct3_q[1:0];
    case (funct3_q[1:0])
      2'b00:   sign_bit = shifted[7];
      2'b01:   sign_bit = shifted[15];
      2'b10:   sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_W-1];
    endcase
    ld_val = shifted;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= nbits) ld_val[i] = sign_bit & ~funct3_q[2];
    end
  end

  // Output decode: dmem side driven only in WAIT, response side only in RESP.
  always_comb begin
    req_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    dmem_addr  = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
    rsp_valid  = 1'b0;
    rsp_we     = 1'b0;
    rsp_rd_s   = '0;
    rsp_rd_v   = '0;
    rsp_fault  = 1'b0;
    if (state_q == WAIT) begin
      dmem_addr  = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
      dmem_wdata = wdata_q << {off, 3'b000};
      if (first_q) begin
        if (store_q) dmem_wmask = lane_mask;
        else         dmem_rmask = lane_mask;
      end
    end
    if (state_q == RESP) begin
      rsp_valid = 1'b1;
      rsp_fault = fault_q;
      rsp_rd_s  = rd_q;
      if (!fault_q && !store_q) begin
        rsp_we   = (rd_q != 5'd0);
        rsp_rd_v = ld_val;
      end
    end
  end

  assign wait_cnt = wcnt_q;

  // State and capture registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= '0;
      fault_q  <= 1'b0;
      first_q  <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      fault_q  <= fault_d;
      first_q  <= first_d;
      wcnt_q   <= wcnt_d;
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: drives a 32-bit and a 64-bit instance with the same requests and
// checks every cycle against a byte-arithmetic reference model.
module tb_dmem_lsu;
  logic        clk, rst;
  logic        req_valid, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, dmem_rdata;
  logic [4:0]  req_rd_s;
  logic        resp32, resp64;

  logic rdy32, busy32, v32, we32, f32, rdy64, busy64, v64, we64, f64;
  logic [31:0] addr32, addr64, wd32, rv32;
  logic [3:0]  rm32, wm32;
  logic [7:0]  rm64, wm64;
  logic [63:0] wd64, rv64;
  logic [4:0]  rds32, rds64;
  logic [15:0] wc32, wc64;

  dmem_lsu #(.DATA_W(32)) u32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy32), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_rd_s(req_rd_s),
    .dmem_addr(addr32), .dmem_rmask(rm32), .dmem_wmask(wm32), .dmem_wdata(wd32),
    .dmem_rdata(dmem_rdata[31:0]), .dmem_resp(resp32), .rsp_valid(v32), .rsp_we(we32),
    .rsp_rd_s(rds32), .rsp_rd_v(rv32), .rsp_fault(f32), .busy(busy32), .wait_cnt(wc32));

  dmem_lsu #(.DATA_W(64)) u64 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy64), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd_s(req_rd_s),
    .dmem_addr(addr64), .dmem_rmask(rm64), .dmem_wmask(wm64), .dmem_wdata(wd64),
    .dmem_rdata(dmem_rdata), .dmem_resp(resp64), .rsp_valid(v64), .rsp_we(we64),
    .rsp_rd_s(rds64), .rsp_rd_v(rv64), .rsp_fault(f64), .busy(busy64), .wait_cnt(wc64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic rdy; logic busy; logic [31:0] addr; logic [7:0] rm; logic [7:0] wm; logic [63:0] wd;
    logic v; logic we; logic [4:0] rd; logic [63:0] rv; logic f; logic [15:0] wc;
  } out_t;

  typedef struct {
    bit st; logic [2:0] f3; logic [31:0] a; logic [63:0] wd; logic [63:0] rdat; logic [4:0] rd;
    int k; int w; logic [7:0] e_mask; logic [31:0] e_addr; logic [63:0] e_wd; logic [63:0] e_rv;
    bit e_f; int e_lat;
  } vec_t;

  int checks = 0, errors = 0, ntxn = 0;

  // Reference model results, per instance (0 = 32-bit, 1 = 64-bit).
  bit          m_flt[2], m_we[2], m_st[2];
  logic [7:0]  m_mask[2];
  logic [31:0] m_addr[2];
  logic [63:0] m_wd[2], m_rv[2];
  logic [4:0]  m_rd[2];
  logic [15:0] wc_prev[2];
  logic [7:0]  obs_mask[2];
  logic [31:0] obs_addr[2];
  logic [63:0] obs_wd[2], obs_rv[2];
  bit          obs_f[2];
  int          obs_lat[2];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic out_t sample(input int d);
    out_t o;
    if (d == 0) begin
      o = '{rdy32, busy32, addr32, {4'b0, rm32}, {4'b0, wm32}, {32'b0, wd32}, v32, we32, rds32,
            {32'b0, rv32}, f32, wc32};
    end else begin
      o = '{rdy64, busy64, addr64, rm64, wm64, wd64, v64, we64, rds64, rv64, f64, wc64};
    end
    return o;
  endfunction

  // Behavioural model: byte offset / size arithmetic on wide integers.
  task automatic set_model(input int d, input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [63:0] wd, input logic [63:0] rdat, input logic [4:0] rd);
    int unsigned B, size, off;
    logic [127:0] big, lmask, v;
    B = (d == 0) ? 4 : 8;
    size = 1 << f3[1:0];
    m_flt[d] = (f3 == 3'b111) || (st && f3[2]) ||
               (B == 4 && (f3[1:0] == 2'b11 || f3 == 3'b110)) || ((a % size) != 0);
    off = a % B;
    m_mask[d] = 8'(((1 << size) - 1) << off);
    m_addr[d] = a - off;
    big = 128'(wd) << (8 * off);
    if (B == 4) big = big & 128'hFFFF_FFFF;
    m_wd[d] = big[63:0];
    v = 128'(rdat);
    if (B == 4) v = v & 128'hFFFF_FFFF;
    v = v >> (8 * off);
    lmask = (128'd1 << (8 * size)) - 128'd1;
    v = v & lmask;
    if (!f3[2] && v[8 * size - 1]) v = v | ~lmask;
    if (B == 4) v = v & 128'hFFFF_FFFF;
    m_st[d] = st;
    m_rd[d] = rd;
    m_we[d] = !m_flt[d] && !st && (rd != 5'd0);
    m_rv[d] = (!m_flt[d] && !st) ? v[63:0] : 64'd0;
  endtask

  // Expected outputs for phase 0 = waiting on memory, 1 = response cycle, 2 = idle.
  function automatic out_t build(input int d, input int ph, input bit first, input logic [15:0] wc);
    out_t e = '0;
    e.wc = wc;
    if (ph == 0) begin
      e.busy = 1'b1; e.addr = m_addr[d]; e.wd = m_wd[d];
      if (first) begin
        if (m_st[d]) e.wm = m_mask[d]; else e.rm = m_mask[d];
      end
    end else if (ph == 1) begin
      e.busy = 1'b1; e.v = 1'b1; e.we = m_we[d]; e.rd = m_rd[d]; e.rv = m_rv[d]; e.f = m_flt[d];
    end else begin
      e.rdy = 1'b1;
    end
    return e;
  endfunction

  function automatic out_t msk(input out_t o, input bit no_dm, input bit no_wc, input bit no_rd, input bit no_rdy);
    out_t r = o;
    if (no_dm) begin r.addr = '0; r.wd = '0; end
    if (no_wc) r.wc = '0;
    if (no_rd) r.rd = '0;
    if (no_rdy) r.rdy = 1'b0;
    return r;
  endfunction

  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [63:0] wd,
                         input logic [63:0] rdat, input logic [4:0] rd, input int k);
    int endc[2];
    int last, ph;
    out_t e, act;
    logic [15:0] wc;
    bit r;
    for (int d = 0; d < 2; d++) begin
      set_model(d, st, f3, a, wd, rdat, rd);
      endc[d] = m_flt[d] ? 1 : k + 2;
      obs_mask[d] = '0; obs_addr[d] = '0; obs_wd[d] = '0; obs_rv[d] = '0; obs_f[d] = 1'b0; obs_lat[d] = -1;
    end
    last = (endc[0] > endc[1]) ? endc[0] : endc[1];
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd_s = rd;
    dmem_rdata = rdat;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom;
    req_wdata = {$urandom, $urandom}; req_rd_s = 5'($urandom);
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ph = (c < endc[d]) ? 0 : ((c == endc[d]) ? 1 : 2);
        wc = m_flt[d] ? wc_prev[d] : 16'(k + 1);
        e = build(d, ph, c == 1, wc);
        act = sample(d);
        if (obs_mask[d] == 8'd0 && (act.rm | act.wm) != 8'd0) begin
          obs_mask[d] = act.rm | act.wm; obs_addr[d] = act.addr; obs_wd[d] = act.wd;
        end
        if (act.v && obs_lat[d] < 0) begin
          obs_lat[d] = c; obs_rv[d] = act.rv; obs_f[d] = act.f;
        end
        e   = msk(e,   ph != 0, ph == 0, ph == 1 && !m_we[d], 1'b0);
        act = msk(act, ph != 0, ph == 0, ph == 1 && !m_we[d], 1'b0);
        chk($sformatf("txn%0d_w%0d_c%0d", ntxn, d, c), 256'(act), 256'(e));
        r = (!m_flt[d] && c == k + 1) || (c >= endc[d] && $urandom_range(1, 0) == 1);
        if (d == 0) resp32 = r; else resp64 = r;
      end
    end
    resp32 = 1'b0; resp64 = 1'b0;
    for (int d = 0; d < 2; d++) if (!m_flt[d]) wc_prev[d] = 16'(k + 1);
    ntxn++;
  endtask

  vec_t tbl[11];
  out_t idle_e;

  initial begin
    tbl[0]  = '{1'b0, 3'b000, 32'h1003, 64'h0,    64'h80FF_FF12, 5'd5, 2, 0, 8'h08, 32'h1000, 64'h0, 64'hFFFF_FF80, 1'b0, 4};
    tbl[1]  = '{1'b1, 3'b001, 32'h2002, 64'hBEEF, 64'h0,         5'd0, 0, 0, 8'h0C, 32'h2000, 64'hBEEF_0000, 64'h0, 1'b0, 2};
    tbl[2]  = '{1'b0, 3'b010, 32'h3001, 64'h0,    64'h1234,      5'd4, 1, 0, 8'h00, 32'h0, 64'h0, 64'h0, 1'b1, 1};
    tbl[3]  = '{1'b0, 3'b011, 32'h3000, 64'h0,    64'h1234,      5'd4, 1, 0, 8'h00, 32'h0, 64'h0, 64'h0, 1'b1, 1};
    tbl[4]  = '{1'b0, 3'b110, 32'h4004, 64'h0,    64'h8765_4321_0000_0000, 5'd7, 1, 1, 8'hF0, 32'h4000, 64'h0, 64'h8765_4321, 1'b0, 3};
    tbl[5]  = '{1'b1, 3'b000, 32'h0007, 64'hAB,   64'h0,         5'd2, 0, 1, 8'h80, 32'h0, 64'hAB00_0000_0000_0000, 64'h0, 1'b0, 2};
    tbl[6]  = '{1'b0, 3'b100, 32'h0005, 64'h0,    64'h0000_AA00_0000_0000, 5'd1, 3, 1, 8'h20, 32'h0, 64'h0, 64'hAA, 1'b0, 5};
    tbl[7]  = '{1'b1, 3'b110, 32'h0000, 64'h55,   64'h0,         5'd3, 0, 1, 8'h00, 32'h0, 64'h0, 64'h0, 1'b1, 1};
    tbl[8]  = '{1'b0, 3'b111, 32'h0000, 64'h0,    64'h0,         5'd3, 0, 1, 8'h00, 32'h0, 64'h0, 64'h0, 1'b1, 1};
    tbl[9]  = '{1'b0, 3'b011, 32'h0008, 64'h0,    64'hFEDC_BA98_7654_3210, 5'd9, 0, 1, 8'hFF, 32'h8, 64'h0, 64'hFEDC_BA98_7654_3210, 1'b0, 2};
    tbl[10] = '{1'b0, 3'b001, 32'h0006, 64'h0,    64'h8001_0000, 5'd6, 1, 0, 8'h0C, 32'h4, 64'h0, 64'hFFFF_8001, 1'b0, 3};

    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    req_rd_s = '0; dmem_rdata = '0; resp32 = 1'b0; resp64 = 1'b0;
    wc_prev[0] = '0; wc_prev[1] = '0;
    idle_e = '0; idle_e.rdy = 1'b1;

    // Outputs during and right after reset.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("in_reset_w%0d", d), 256'(msk(sample(d), 0, 0, 0, 1)), 256'(out_t'('0)));
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("after_reset_w%0d", d), 256'(sample(d)), 256'(idle_e));

    // Directed vectors with hand-derived lane/result expectations.
    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rdat, tbl[i].rd, tbl[i].k);
      chk($sformatf("tbl%0d_lane", i), 256'({obs_mask[tbl[i].w], obs_addr[tbl[i].w], obs_wd[tbl[i].w]}),
          256'({tbl[i].e_mask, tbl[i].e_addr, tbl[i].e_wd}));
      chk($sformatf("tbl%0d_rsp", i), 256'({obs_rv[tbl[i].w], obs_f[tbl[i].w], obs_lat[tbl[i].w]}),
          256'({tbl[i].e_rv, tbl[i].e_f, tbl[i].e_lat}));
    end

    // Reset in the middle of an access; the stale completion must be ignored.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_rd_s = 5'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("mid_wait_reset_w%0d", d), 256'(msk(sample(d), 0, 0, 0, 1)), 256'(out_t'('0)));
    @(negedge clk);
    rst = 1'b0; resp32 = 1'b1; resp64 = 1'b1;
    @(negedge clk);
    resp32 = 1'b0; resp64 = 1'b0;
    for (int d = 0; d < 2; d++) chk($sformatf("stale_resp_w%0d_a", d), 256'(sample(d)), 256'(idle_e));
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("stale_resp_w%0d_b", d), 256'(sample(d)), 256'(idle_e));
    wc_prev[0] = '0; wc_prev[1] = '0;
    run_txn(1'b0, 3'b010, 32'h100, 64'h0, 64'h1122_3344_5566_7788, 5'd3, 1);

    // Randomised traffic, mostly aligned addresses.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      f3 = 3'($urandom);
      a = $urandom;
      if ($urandom_range(3, 0) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      run_txn(1'($urandom), f3, a, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), $urandom_range(4, 0));
    end

    // Very long stall: the WAIT counter must saturate.
    set_model(0, 1'b0, 3'b000, 32'h0, 64'h0, 64'h0, 5'd8);
    set_model(1, 1'b0, 3'b000, 32'h0, 64'h0, 64'h0, 5'd8);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = '0;
    req_rd_s = 5'd8; dmem_rdata = 64'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (70000) @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("stall_w%0d", d), 256'(sample(d)), 256'(build(d, 0, 1'b0, 16'hFFFF)));
    resp32 = 1'b1; resp64 = 1'b1;
    @(negedge clk);
    resp32 = 1'b0; resp64 = 1'b0;
    for (int d = 0; d < 2; d++) chk($sformatf("stall_rsp_w%0d", d), 256'(sample(d)), 256'(build(d, 1, 1'b0, 16'hFFFF)));
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("stall_idle_w%0d", d), 256'(sample(d)), 256'(build(d, 2, 1'b0, 16'hFFFF)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
